// File: rtl/operand_feeder_if.sv
// Host-write / run-control / operand bus between operand_feeder and its neighbours.
interface operand_feeder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_UNITS  = 4,
    parameter int DEPTH      = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                                  wr_en;
    logic [1:0]                            wr_sel;
    logic [AW-1:0]                         wr_addr;
    logic [NUM_UNITS*DATA_WIDTH-1:0]       wr_data;
    logic                                  start;
    logic [AW:0]                           length;
    logic [NUM_UNITS-1:0]                  active_units;
    logic                                  array_done;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  a_in_array;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  b_in_array;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  bias_array;
    logic                                  dpu_start;
    logic                                  busy;
    logic                                  done;
    logic                                  err;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, length, active_units, array_done,
        input  a_in_array, b_in_array, bias_array, dpu_start, busy, done, err
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, length, active_units, array_done,
        output a_in_array, b_in_array, bias_array, dpu_start, busy, done, err
    );
endinterface

// File: rtl/operand_feeder.sv
// Operand bank + sequencer feeding the dot-product unit one A/B vector per pass.
// Optional lane masking on the outputs is enabled by defining FEEDER_LANE_MASK_EN.
module operand_feeder_lane #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic [DATA_WIDTH-1:0] bias_o
);
    assign a_o    = en ? a    : '0;
    assign b_o    = en ? b    : '0;
    assign bias_o = en ? bias : '0;
endmodule

module operand_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_UNITS  = 4,
    parameter int DEPTH      = 16
) (
    input  logic          clk,
    input  logic          reset,
    operand_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(DEPTH);

    typedef logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] vec_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

    vec_t          a_bank [DEPTH];
    vec_t          b_bank [DEPTH];
    state_t        state;
    logic [AW-1:0] idx;
    logic [LW-1:0] len;
    vec_t          a_q, b_q, bias_q;
    logic          dpu_start_q, busy_q, done_q, err_q;

    logic          wr_ok, start_ok;
    logic [LW-1:0] idx_inc;

    assign wr_ok    = reset && bus.wr_en && (state == IDLE) && (bus.wr_sel != 2'd3);
    assign start_ok = (bus.length != '0) && (bus.length <= MAX_LEN);
    assign idx_inc  = {1'b0, idx} + {{AW{1'b0}}, 1'b1};

    // Banks are plain storage: reset leaves their contents alone.
    always_ff @(posedge clk) begin
        if (wr_ok && bus.wr_sel == 2'd0) a_bank[bus.wr_addr] <= bus.wr_data;
        if (wr_ok && bus.wr_sel == 2'd1) b_bank[bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            len         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            bias_q      <= '0;
            dpu_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            dpu_start_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= bus.wr_en && !wr_ok;
            if (wr_ok && bus.wr_sel == 2'd2) bias_q <= bus.wr_data;
            case (state)
                IDLE: if (bus.start) begin
                    if (start_ok) begin
                        state       <= ISSUE;
                        len         <= bus.length;
                        idx         <= '0;
                        a_q         <= a_bank[0];
                        b_q         <= b_bank[0];
                        dpu_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                ISSUE: state <= WAIT;
                // Consumer restarts itself on the new operands; no further dpu_start.
                WAIT: if (bus.array_done) begin
                    if (idx_inc < len) begin
                        idx <= idx_inc[AW-1:0];
                        a_q <= a_bank[idx_inc[AW-1:0]];
                        b_q <= b_bank[idx_inc[AW-1:0]];
                    end else begin
                        state  <= FIN;
                        done_q <= 1'b1;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [NUM_UNITS-1:0] lane_en;
`ifdef FEEDER_LANE_MASK_EN
    assign lane_en = bus.active_units;
`else
    logic unused_active_units;
    assign unused_active_units = ^bus.active_units;
    assign lane_en = '1;
`endif

    vec_t a_m, b_m, bias_m;
    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_lane
        operand_feeder_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .en    (lane_en[i]),
            .a     (a_q[i]),
            .b     (b_q[i]),
            .bias  (bias_q[i]),
            .a_o   (a_m[i]),
            .b_o   (b_m[i]),
            .bias_o(bias_m[i])
        );
    end

    assign bus.a_in_array = a_m;
    assign bus.b_in_array = b_m;
    assign bus.bias_array = bias_m;
    assign bus.dpu_start  = dpu_start_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_operand_feeder.sv
// Self-checking bench for operand_feeder: directed scenarios plus randomized runs vs a bank model.
module tb_operand_feeder;
    localparam int DW = 16, NU = 4, DEPTH = 16, AW = 4;
    typedef logic [NU-1:0][DW-1:0] vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    operand_feeder_if #(.DATA_WIDTH(DW), .NUM_UNITS(NU), .DEPTH(DEPTH)) bus();
    operand_feeder #(.DATA_WIDTH(DW), .NUM_UNITS(NU), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    vec_t ma [DEPTH];
    vec_t mb [DEPTH];
    vec_t mbias = '0;

    function automatic vec_t mkvec(int x0, int x1, int x2, int x3);
        vec_t v;
        v[0] = x0[DW-1:0]; v[1] = x1[DW-1:0]; v[2] = x2[DW-1:0]; v[3] = x3[DW-1:0];
        return v;
    endfunction

    function automatic vec_t rvec();
        vec_t v;
        for (int i = 0; i < NU; i++) v[i] = DW'($urandom);
        return v;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Host write; the model records it only when the feeder should accept it.
    task automatic wr(input logic [1:0] sel, input int addr, input vec_t d, input bit idle);
        bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_addr = addr[AW-1:0]; bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
        if (idle) case (sel)
            2'd0: ma[addr] = d;
            2'd1: mb[addr] = d;
            2'd2: mbias = d;
            default: ;
        endcase
    endtask

    task automatic test_reset();
        checks++; if (bus.a_in_array !== '0) begin errors++; $display("FAIL reset_a got %h exp 0", bus.a_in_array); end
        checks++; if (bus.b_in_array !== '0) begin errors++; $display("FAIL reset_b got %h exp 0", bus.b_in_array); end
        checks++; if (bus.bias_array !== '0) begin errors++; $display("FAIL reset_bias got %h exp 0", bus.bias_array); end
        checks++; if ({bus.dpu_start, bus.busy, bus.done, bus.err} !== 4'b0) begin errors++;
            $display("FAIL reset_flags got %b exp 0000", {bus.dpu_start, bus.busy, bus.done, bus.err}); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int starts;
        wr(2'd0, 0, mkvec(1, 2, 3, 4), 1);
        wr(2'd0, 1, mkvec(5, 6, 7, 8), 1);
        wr(2'd0, 2, mkvec(9, 10, 11, 12), 1);
        for (int i = 0; i < 3; i++) wr(2'd1, i, mkvec(2, 2, 2, 2), 1);
        wr(2'd2, 0, mkvec(1, 1, 1, 1), 1);
        checks++; if (bus.bias_array !== mbias) begin errors++; $display("FAIL basic_bias got %h exp %h", bus.bias_array, mbias); end
        bus.length = 3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        starts = int'(bus.dpu_start);
        checks++; if (bus.dpu_start !== 1'b1 || bus.busy !== 1'b1) begin errors++;
            $display("FAIL basic_issue got dpu_start=%b busy=%b exp 1 1", bus.dpu_start, bus.busy); end
        checks++; if (bus.a_in_array !== ma[0] || bus.b_in_array !== mb[0]) begin errors++;
            $display("FAIL basic_vec0 got a=%h b=%h exp a=%h b=%h", bus.a_in_array, bus.b_in_array, ma[0], mb[0]); end
        for (int j = 0; j < 3; j++) begin
            repeat (4) begin
                step();
                starts += int'(bus.dpu_start);
                checks++; if (bus.a_in_array !== ma[j]) begin errors++; $display("FAIL basic_hold got %h exp %h", bus.a_in_array, ma[j]); end
            end
            bus.array_done = 1'b1;
            step();
            bus.array_done = 1'b0;
            if (j < 2) begin
                checks++; if (bus.a_in_array !== ma[j+1] || bus.done !== 1'b0) begin errors++;
                    $display("FAIL basic_step%0d got a=%h done=%b exp a=%h done=0", j, bus.a_in_array, bus.done, ma[j+1]); end
            end else begin
                checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", bus.done); end
            end
        end
        step();
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.a_in_array !== ma[2]) begin errors++;
            $display("FAIL basic_end got done=%b busy=%b a=%h exp 0 0 %h", bus.done, bus.busy, bus.a_in_array, ma[2]); end
        checks++; if (starts != 1) begin errors++; $display("FAIL basic_start_count got %0d exp 1", starts); end
    endtask

    task automatic test_illegal_length();
        int bad [2] = '{0, DEPTH + 1};
        foreach (bad[n]) begin
            bus.length = bad[n][AW:0]; bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.dpu_start !== 1'b0) begin errors++;
                $display("FAIL illegal_len%0d got err=%b busy=%b dpu_start=%b exp 1 0 0", bad[n], bus.err, bus.busy, bus.dpu_start); end
            step();
            checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.dpu_start !== 1'b0) begin errors++;
                $display("FAIL illegal_after%0d got err=%b busy=%b dpu_start=%b exp 0 0 0", bad[n], bus.err, bus.busy, bus.dpu_start); end
        end
    endtask

    task automatic test_write_busy();
        bus.length = 1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        wr(2'd0, 0, '1, 0);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL busy_write_err got %b exp 1", bus.err); end
        bus.array_done = 1'b1;
        step();
        bus.array_done = 1'b0;
        step();
        wr(2'd3, 0, rvec(), 1);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL sel3_err got %b exp 1", bus.err); end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.a_in_array !== ma[0]) begin errors++; $display("FAIL busy_write_a0 got %h exp %h", bus.a_in_array, ma[0]); end
        step();
        bus.array_done = 1'b1;
        step();
        bus.array_done = 1'b0;
        step();
    endtask

    task automatic test_start_at_fin();
        bus.length = 2; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                bus.start = 1'b1;
                step();
                bus.start = 1'b0;
                checks++; if (bus.err !== 1'b0 || bus.dpu_start !== 1'b0) begin errors++;
                    $display("FAIL start_busy got err=%b dpu_start=%b exp 0 0", bus.err, bus.dpu_start); end
            end
            bus.array_done = 1'b1;
            step();
            bus.array_done = 1'b0;
        end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL fin_done got %b exp 1", bus.done); end
        bus.start = 1'b1; bus.length = 1;
        step();
        checks++; if (bus.busy !== 1'b0 || bus.dpu_start !== 1'b0 || bus.err !== 1'b0) begin errors++;
            $display("FAIL fin_start_idle got busy=%b dpu_start=%b err=%b exp 0 0 0", bus.busy, bus.dpu_start, bus.err); end
        step();
        bus.start = 1'b0;
        checks++; if (bus.dpu_start !== 1'b1 || bus.a_in_array !== ma[0]) begin errors++;
            $display("FAIL fin_restart got dpu_start=%b a=%h exp 1 %h", bus.dpu_start, bus.a_in_array, ma[0]); end
        step();
        bus.array_done = 1'b1;
        step();
        bus.array_done = 1'b0;
        step();
    endtask

    task automatic test_full_depth();
        int dones = 0;
        for (int i = 0; i < DEPTH; i++) begin
            vec_t v = rvec();
            v[0] = DW'(i);
            wr(2'd0, i, v, 1);
            wr(2'd1, i, rvec(), 1);
        end
        bus.length = DEPTH[AW:0]; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.a_in_array[0] !== 16'd0) begin errors++; $display("FAIL depth_lane0 got %0d exp 0", bus.a_in_array[0]); end
        for (int i = 1; i < DEPTH; i++) begin
            step();
            bus.array_done = 1'b1;
            step();
            bus.array_done = 1'b0;
            dones += int'(bus.done);
            checks++; if (bus.a_in_array !== ma[i] || bus.b_in_array !== mb[i] || bus.a_in_array[0] !== DW'(i)) begin errors++;
                $display("FAIL depth_step%0d got a=%h b=%h exp a=%h b=%h", i, bus.a_in_array, bus.b_in_array, ma[i], mb[i]); end
        end
        bus.array_done = 1'b1;
        step();
        bus.array_done = 1'b0;
        dones += int'(bus.done);
        step();
        dones += int'(bus.done);
        checks++; if (dones != 1) begin errors++; $display("FAIL depth_done_count got %0d exp 1", dones); end
        checks++; if (bus.a_in_array !== ma[DEPTH-1] || bus.busy !== 1'b0) begin errors++;
            $display("FAIL depth_nowrap got a=%h busy=%b exp a=%h busy=0", bus.a_in_array, bus.busy, ma[DEPTH-1]); end
    endtask

    task automatic test_reset_mid_run();
        bus.length = 3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.array_done = 1'b1;
        step();
        bus.array_done = 1'b0;
        checks++; if (bus.a_in_array !== ma[1]) begin errors++; $display("FAIL midrst_step got %h exp %h", bus.a_in_array, ma[1]); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        mbias = '0;
        checks++; if (bus.a_in_array !== '0 || bus.b_in_array !== '0 || bus.bias_array !== '0) begin errors++;
            $display("FAIL midrst_zero got a=%h b=%h bias=%h exp 0", bus.a_in_array, bus.b_in_array, bus.bias_array); end
        checks++; if ({bus.busy, bus.done, bus.dpu_start} !== 3'b0) begin errors++;
            $display("FAIL midrst_flags got %b exp 000", {bus.busy, bus.done, bus.dpu_start}); end
        repeat (3) begin
            step();
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_nodone got %b exp 0", bus.done); end
        end
        bus.length = 1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.a_in_array !== ma[0] || bus.dpu_start !== 1'b1) begin errors++;
            $display("FAIL midrst_fresh got a=%h dpu_start=%b exp %h 1", bus.a_in_array, bus.dpu_start, ma[0]); end
        step();
        bus.array_done = 1'b1;
        step();
        bus.array_done = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            int len;
            repeat ($urandom_range(0, 3)) wr(2'($urandom_range(0, 2)), $urandom_range(0, DEPTH - 1), rvec(), 1);
            if ($urandom_range(0, 1) == 1) begin
                bus.array_done = 1'b1;
                step();
                bus.array_done = 1'b0;
                checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++;
                    $display("FAIL rnd_idle_ad got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
            end
            len = $urandom_range(1, DEPTH);
            bus.length = len[AW:0]; bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            checks++; if (bus.dpu_start !== 1'b1 || bus.a_in_array !== ma[0] || bus.b_in_array !== mb[0]) begin errors++;
                $display("FAIL rnd_issue run %0d got dpu_start=%b a=%h b=%h exp 1 %h %h", r, bus.dpu_start, bus.a_in_array, bus.b_in_array, ma[0], mb[0]); end
            // array_done during the ISSUE cycle must be ignored
            bus.array_done = 1'($urandom_range(0, 1));
            step();
            bus.array_done = 1'b0;
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 3)) begin
                    bus.start = 1'($urandom_range(0, 1));
                    step();
                    checks++; if (bus.a_in_array !== ma[k] || bus.b_in_array !== mb[k] || bus.dpu_start !== 1'b0 || bus.err !== 1'b0) begin errors++;
                        $display("FAIL rnd_hold run %0d k %0d got a=%h b=%h dpu_start=%b err=%b exp %h %h 0 0", r, k, bus.a_in_array, bus.b_in_array, bus.dpu_start, bus.err, ma[k], mb[k]); end
                end
                bus.start = 1'b0;
                bus.array_done = 1'b1;
                step();
                bus.array_done = 1'b0;
                if (k < len - 1) begin
                    checks++; if (bus.a_in_array !== ma[k+1] || bus.b_in_array !== mb[k+1] || bus.done !== 1'b0) begin errors++;
                        $display("FAIL rnd_step run %0d k %0d got a=%h done=%b exp %h 0", r, k, bus.a_in_array, bus.done, ma[k+1]); end
                end else begin
                    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rnd_done run %0d got %b exp 1", r, bus.done); end
                end
            end
            step();
            checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bias_array !== mbias) begin errors++;
                $display("FAIL rnd_end run %0d got busy=%b done=%b bias=%h exp 0 0 %h", r, bus.busy, bus.done, bus.bias_array, mbias); end
        end
    endtask

    task automatic test_mask();
        vec_t ea, eb;
        wr(2'd0, 0, mkvec(11, 22, 33, 44), 1);
        wr(2'd2, 0, mkvec(5, 6, 7, 8), 1);
        bus.length = 1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.active_units = 4'b0101;
        #1;
        ea = ma[0]; eb = mbias;
`ifdef FEEDER_LANE_MASK_EN
        ea[1] = '0; ea[3] = '0; eb[1] = '0; eb[3] = '0;
`endif
        checks++; if (bus.a_in_array !== ea) begin errors++; $display("FAIL mask_a got %h exp %h", bus.a_in_array, ea); end
        checks++; if (bus.bias_array !== eb) begin errors++; $display("FAIL mask_bias got %h exp %h", bus.bias_array, eb); end
        bus.active_units = '1;
        #1;
        checks++; if (bus.a_in_array !== ma[0]) begin errors++; $display("FAIL mask_clear got %h exp %h", bus.a_in_array, ma[0]); end
        step();
        bus.array_done = 1'b1;
        step();
        bus.array_done = 1'b0;
        step();
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.length = '0; bus.active_units = '1; bus.array_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin ma[i] = 'x; mb[i] = 'x; end
        step(); step();
        test_reset();
        test_basic();
        test_illegal_length();
        test_write_busy();
        test_start_at_fin();
        test_full_depth();
        test_reset_mid_run();
        test_random();
        test_mask();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
